// File: rtl/ssd_pkg.sv
// Shared definitions for the seven-segment scan decoder: glyph constants,
// decoder FSM states, digit count and an anode-select helper.
// Glyphs are lit patterns in HGFEDCBA order; the bus carries their complements.
package ssd_pkg;

    localparam int NUM_DIGITS = 4;

    localparam logic [7:0] SEG_0 = 8'h3F;
    localparam logic [7:0] SEG_1 = 8'h06;
    localparam logic [7:0] SEG_2 = 8'h5B;
    localparam logic [7:0] SEG_3 = 8'h4F;
    localparam logic [7:0] SEG_4 = 8'h66;
    localparam logic [7:0] SEG_5 = 8'h6D;
    localparam logic [7:0] SEG_6 = 8'h7D;
    localparam logic [7:0] SEG_7 = 8'h07;
    localparam logic [7:0] SEG_8 = 8'h7F;
    localparam logic [7:0] SEG_9 = 8'h6F;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        HOLD   = 2'd2
    } state_t;

    // Returns {selectable, digit index}; selectable only when exactly one
    // active-low anode is driven.
    function automatic logic [2:0] an_select(input logic [3:0] an);
        logic [2:0] r;
        case (an)
            4'b1110: r = 3'b1_00;
            4'b1101: r = 3'b1_01;
            4'b1011: r = 3'b1_10;
            4'b0111: r = 3'b1_11;
            default: r = 3'b0_00;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/ssd_glyph_decoder.sv
// Purpose: map an active-low seven-segment pattern (GFEDCBA) to a BCD nibble.
// Latency: combinational, zero cycles.
// Backpressure: none; hit=0 flags a pattern that is not a decimal glyph.
import ssd_pkg::*;

module ssd_glyph_decoder (
    input  logic [6:0] seg,
    output logic       hit,
    output logic [3:0] nibble
);

    logic [6:0] lit;

    assign lit = ~seg;

    // Exact-match lookup against the lit glyph table.
    always_comb begin
        hit    = 1'b1;
        nibble = 4'd0;
        case (lit)
            SEG_0[6:0]: nibble = 4'd0;
            SEG_1[6:0]: nibble = 4'd1;
            SEG_2[6:0]: nibble = 4'd2;
            SEG_3[6:0]: nibble = 4'd3;
            SEG_4[6:0]: nibble = 4'd4;
            SEG_5[6:0]: nibble = 4'd5;
            SEG_6[6:0]: nibble = 4'd6;
            SEG_7[6:0]: nibble = 4'd7;
            SEG_8[6:0]: nibble = 4'd8;
            SEG_9[6:0]: nibble = 4'd9;
            default:    hit    = 1'b0;
        endcase
    end

endmodule

// File: rtl/ssd_scan_decoder.sv
// Purpose: rebuild four BCD digits from a multiplexed 7-seg bus (SSD_DP_CAPTURE_EN adds dp capture).
// Latency: capture lands SETTLE_CYCLES edges after the first sample edge (sample stage adds one).
// Backpressure: none; passive bus monitor, frame_done/err are single-cycle pulses.
import ssd_pkg::*;

module ssd_scan_decoder #(
    parameter int SETTLE_CYCLES = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  seg,
    input  logic [3:0]  an,
    output logic [15:0] digits,
    output logic [3:0]  dp,
    output logic [3:0]  valid,
    output logic        frame_done,
    output logic        err,
    output logic [1:0]  err_digit
);

    localparam int             CW      = $clog2(SETTLE_CYCLES + 1);
    localparam logic [CW-1:0]  CNT_SAT = CW'(SETTLE_CYCLES);

    logic [7:0]            seg_in;
    logic [3:0]            s_an, p_an;
    logic [7:0]            s_seg, p_seg;
    logic [2:0]            sel;
    logic                  sel_ok;
    logic [1:0]            sel_idx;
    logic                  changed;
    logic [CW-1:0]         cnt, cnt_nxt;
    state_t                state, state_nxt;
    logic                  capture;
    logic                  glyph_hit;
    logic [3:0]            glyph_nib;
    logic [NUM_DIGITS-1:0] mask_q, mask_new;
    logic [15:0]           digits_q;
    logic [NUM_DIGITS-1:0] valid_q;
    logic                  fd_q, err_q;
    logic [1:0]            errd_q;

`ifdef SSD_DP_CAPTURE_EN
    assign seg_in = seg;
`else
    // Decimal point is not tracked: pin it unlit so it never restarts a run.
    logic unused_dp;
    assign unused_dp = seg[7];
    assign seg_in    = {1'b1, seg[6:0]};
`endif

    // Sample the bus, and keep the prior sample for change detection.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s_an  <= 4'hF;
            s_seg <= 8'hFF;
            p_an  <= 4'hF;
            p_seg <= 8'hFF;
        end else begin
            s_an  <= an;
            s_seg <= seg_in;
            p_an  <= s_an;
            p_seg <= s_seg;
        end
    end

    assign sel     = an_select(s_an);
    assign sel_ok  = sel[2];
    assign sel_idx = sel[1:0];
    assign changed = ({s_an, s_seg} != {p_an, p_seg});

    // Run length of identical selectable samples, saturating at the threshold.
    always_comb begin
        cnt_nxt = '0;
        if (!sel_ok)
            cnt_nxt = '0;
        else if (changed)
            cnt_nxt = CW'(1);
        else if (cnt == CNT_SAT)
            cnt_nxt = cnt;
        else
            cnt_nxt = cnt + CW'(1);
    end

    // Run counter register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cnt <= '0;
        else
            cnt <= cnt_nxt;
    end

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // FSM next state: blank drops to IDLE, a full run parks in HOLD.
    always_comb begin
        state_nxt = state;
        if (!sel_ok)
            state_nxt = IDLE;
        else if (cnt_nxt == CNT_SAT)
            state_nxt = HOLD;
        else
            state_nxt = SETTLE;
    end

    // FSM output: one capture per stable window. With a threshold of one a
    // changed sample in HOLD is itself a complete new window.
    always_comb begin
        capture = 1'b0;
        if (sel_ok && (cnt_nxt == CNT_SAT) && ((state != HOLD) || changed))
            capture = 1'b1;
    end

    ssd_glyph_decoder u_glyph (
        .seg    (s_seg[6:0]),
        .hit    (glyph_hit),
        .nibble (glyph_nib)
    );

    assign mask_new = mask_q | (4'b0001 << sel_idx);

    // Capture registers, frame tracking and single-cycle status pulses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            digits_q <= '0;
            valid_q  <= '0;
            mask_q   <= '0;
            fd_q     <= 1'b0;
            err_q    <= 1'b0;
            errd_q   <= 2'd0;
        end else begin
            fd_q  <= 1'b0;
            err_q <= 1'b0;
            if (capture) begin
                if (glyph_hit) begin
                    digits_q[{sel_idx, 2'b00} +: 4] <= glyph_nib;
                    valid_q[sel_idx]                <= 1'b1;
                    if (mask_new == 4'hF) begin
                        fd_q   <= 1'b1;
                        mask_q <= '0;
                    end else begin
                        mask_q <= mask_new;
                    end
                end else begin
                    err_q  <= 1'b1;
                    errd_q <= sel_idx;
                end
            end
        end
    end

`ifdef SSD_DP_CAPTURE_EN
    logic [NUM_DIGITS-1:0] dp_q;

    // Decimal point follows each good capture of its digit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            dp_q <= '0;
        else if (capture && glyph_hit)
            dp_q[sel_idx] <= ~s_seg[7];
    end

    assign dp = dp_q;
`else
    assign dp = 4'b0000;
`endif

    assign digits     = digits_q;
    assign valid      = valid_q;
    assign frame_done = fd_q;
    assign err        = err_q;
    assign err_digit  = errd_q;

endmodule

// File: tb/tb_ssd_scan_decoder.sv
// Bench for ssd_scan_decoder: directed scenarios then random scan traffic,
// every cycle compared against a run-length reference model.
// Model reasons on "value seen N times in a row on the bus" rather than FSM state.
`timescale 1ns/1ps

module tb_ssd_scan_decoder;

    localparam int S = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  seg;
    logic [3:0]  an;
    logic [15:0] digits;
    logic [3:0]  dp;
    logic [3:0]  valid;
    logic        frame_done;
    logic        err;
    logic [1:0]  err_digit;

    ssd_scan_decoder #(.SETTLE_CYCLES(S)) dut (
        .clk        (clk),
        .rst        (rst),
        .seg        (seg),
        .an         (an),
        .digits     (digits),
        .dp         (dp),
        .valid      (valid),
        .frame_done (frame_done),
        .err        (err),
        .err_digit  (err_digit)
    );

    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    endtask

    // Lit glyph table for digits 0..9 (GFEDCBA).
    logic [6:0] glyph [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                               7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

    // Reference model state.
    logic [15:0] exp_digits;
    logic [3:0]  exp_valid, exp_dp, exp_mask;
    logic        exp_fd, exp_err;
    logic [1:0]  exp_errd;
    logic [11:0] prev_val;
    int          run_len;

    task automatic model_reset();
        exp_digits = '0;
        exp_valid  = '0;
        exp_dp     = '0;
        exp_mask   = '0;
        exp_fd     = 1'b0;
        exp_err    = 1'b0;
        exp_errd   = '0;
        prev_val   = 12'hFFF;
        run_len    = 0;
    endtask

    // Consume one bus sample; results describe the outputs one edge later.
    task automatic model_step(input logic [3:0] a, input logic [7:0] s);
        logic [11:0] cur;
        int          nz, idx, g;
        logic [6:0]  lit;
        cur = {a, s};
`ifndef SSD_DP_CAPTURE_EN
        cur[7] = 1'b1;
`endif
        nz  = 0;
        idx = 0;
        for (int i = 0; i < 4; i++)
            if (!a[i]) begin
                nz++;
                idx = i;
            end
        exp_fd  = 1'b0;
        exp_err = 1'b0;
        if (nz != 1)
            run_len = 0;
        else if (cur == prev_val)
            run_len++;
        else
            run_len = 1;
        prev_val = cur;
        if (nz == 1 && run_len == S) begin
            lit = ~s[6:0];
            g   = -1;
            for (int k = 0; k < 10; k++)
                if (glyph[k] == lit) g = k;
            if (g >= 0) begin
                exp_digits[idx*4 +: 4] = 4'(g);
                exp_valid[idx]         = 1'b1;
`ifdef SSD_DP_CAPTURE_EN
                exp_dp[idx]            = ~s[7];
`endif
                exp_mask[idx] = 1'b1;
                if (exp_mask == 4'hF) begin
                    exp_fd   = 1'b1;
                    exp_mask = '0;
                end
            end else begin
                exp_err  = 1'b1;
                exp_errd = 2'(idx);
            end
        end
    endtask

    task automatic check_all(input string pfx);
        chk({pfx, ".digits"},     32'(digits),     32'(exp_digits));
        chk({pfx, ".valid"},      32'(valid),      32'(exp_valid));
        chk({pfx, ".dp"},         32'(dp),         32'(exp_dp));
        chk({pfx, ".frame_done"}, 32'(frame_done), 32'(exp_fd));
        chk({pfx, ".err"},        32'(err),        32'(exp_err));
        chk({pfx, ".err_digit"},  32'(err_digit),  32'(exp_errd));
    endtask

    // Drive one bus value for one cycle, check the previous cycle's effect.
    task automatic cyc(input logic [3:0] a, input logic [7:0] s, input string pfx);
        an  = a;
        seg = s;
        @(posedge clk);
        #1;
        check_all(pfx);
        model_step(a, s);
    endtask

    task automatic hold(input logic [3:0] a, input logic [7:0] s, input int n, input string pfx);
        for (int i = 0; i < n; i++)
            cyc(a, s, pfx);
    endtask

    int fd_seen;

    initial begin
        logic [3:0] ra;
        logic [7:0] rs;
        int         r;

        model_reset();
        rst = 1'b1;
        an  = 4'hF;
        seg = 8'hFF;
        repeat (2) @(posedge clk);
        #1;
        check_all("reset");
        rst = 1'b0;

        // Single digit 3 on digit 0: capture visible after the fifth edge.
        hold(4'b1110, 8'hB0, 4, "single_pre");
        chk("single.not_yet", 32'(valid), 32'h0);
        cyc(4'b1110, 8'hB0, "single_cap");
        chk("single.digit0", 32'(digits[3:0]), 32'd3);
        chk("single.valid", 32'(valid), 32'h1);
        hold(4'b1110, 8'hB0, 2, "single_post");
        chk("single.no_frame", 32'(frame_done), 32'h0);

        // Two full frames 1,2,3,4 with six cycles per digit.
        fd_seen = 0;
        for (int f = 0; f < 2; f++) begin
            hold(4'b1110, 8'hF9, 6, "frame");
            hold(4'b1101, 8'hA4, 6, "frame");
            hold(4'b1011, 8'hB0, 6, "frame");
            for (int i = 0; i < 6; i++) begin
                cyc(4'b0111, 8'h99, "frame");
                if (frame_done) fd_seen++;
            end
        end
        chk("frame.digits", 32'(digits), 32'h4321);
        chk("frame.valid", 32'(valid), 32'hF);
        chk("frame.pulses", 32'(fd_seen), 32'd2);

        // Glitch: short 2 then a settled 1 on digit 1.
        hold(4'b1111, 8'hFF, 2, "gap");
        hold(4'b1101, 8'hA4, 2, "glitch");
        hold(4'b1101, 8'hF9, 5, "glitch");
        chk("glitch.digit1", 32'(digits[7:4]), 32'd1);

        // Undecodable glyph on digit 2, then a multi-anode blank.
        hold(4'b1011, 8'hFF, 5, "invalid");
        hold(4'b1100, 8'hB0, 10, "blank");

        // Digit 0 with decimal point lit.
        hold(4'b1110, 8'h40, 6, "dp");
`ifdef SSD_DP_CAPTURE_EN
        chk("dp.lit", 32'(dp[0]), 32'h1);
`else
        chk("dp.off", 32'(dp), 32'h0);
`endif
        chk("dp.digit0", 32'(digits[3:0]), 32'd0);

        // Reset mid-settle after two digits captured.
        hold(4'b1110, 8'hF9, 6, "prerst");
        hold(4'b1101, 8'hA4, 6, "prerst");
        hold(4'b1011, 8'hB0, 2, "prerst");
        #2 rst = 1'b1;
        #1;
        model_reset();
        check_all("midrst");
        @(posedge clk);
        #1 rst = 1'b0;
        hold(4'b1011, 8'hB0, 5, "postrst");
        chk("postrst.digit2", 32'(digits[11:8]), 32'd3);
        chk("postrst.valid", 32'(valid), 32'h4);

        // Random scan traffic.
        for (int n = 0; n < 300; n++) begin
            r = $urandom_range(0, 9);
            if (r == 0)
                ra = ($urandom_range(0, 1) == 0) ? 4'hF : 4'b0011;
            else
                ra = ~(4'b0001 << $urandom_range(0, 3));
            r = $urandom_range(0, 11);
            if (r < 10)
                rs = {1'($urandom_range(0, 1)), ~glyph[r]};
            else if (r == 10)
                rs = 8'hFF;
            else
                rs = 8'($urandom);
            hold(ra, rs, $urandom_range(1, 7), "rand");
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/ssd_scan_decoder.md
# ssd_scan_decoder

Monitors the multiplexed seven-segment drive bus (active-low segments HGFEDCBA, active-low anodes) and reconstructs the four displayed digits as BCD, acting as the receiving end of the seven-segment conversion and scan path. It waits for each anode/segment combination to hold stable for a programmable number of cycles, decodes the glyph, and stores it per digit. It also flags completed frames and undecodable glyphs. It sits on the display bus for loopback self-check and bench scoreboarding.

## Interface
- SETTLE_CYCLES, 4: number of consecutive identical samples required before capture; legal range ≥1.
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- seg  in  8  segment drive, active-low, bit7=H (dp) … bit0=A.
- an  in  4  anode drive, active-low; an[i]=0 selects digit i.
- digits  out  16  captured BCD, digit i in [4i+3:4i].
- dp  out  4  captured decimal-point state per digit, 1 = lit.
- valid  out  4  valid[i]=1 once digit i has been captured since reset (sticky).
- frame_done  out  1  one-cycle pulse when all four digits have been captured in the current frame.
- err  out  1  one-cycle pulse when a settled glyph is undecodable.
- err_digit  out  2  index of the digit of the most recent err; held until the next err.

## Operation
- Sample stage: an and seg are registered every edge into s_an/s_seg; all logic works on the samples.
- A sample is selectable only if exactly one bit of s_an is 0; an all-ones or multiple-zero s_an is blank.
- Run counter (width $clog2(SETTLE_CYCLES+1)): cleared to 0 on a blank sample; set to 1 when a selectable sample differs from the previous sample; incremented while it equals the previous sample; saturates at SETTLE_CYCLES.
- FSM states: IDLE (blank), SETTLE (counting), HOLD (captured, waiting for change).
- IDLE → SETTLE on a selectable sample.
- SETTLE → HOLD when the count reaches SETTLE_CYCLES; a capture fires on that transition.
- HOLD → SETTLE on a changed selectable sample.
- Any state → IDLE on a blank sample.
- Exactly one capture per stable window.
- Decode on s_seg[6:0], active-low, exactly: 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F. These are the lit patterns; the bus carries their complements.
- Valid capture: write the nibble into digit i and set valid[i] and frame mask bit i.
- Invalid pattern: err pulse and err_digit=i; digit i, valid and the mask are unchanged.
- Frame mask: when the mask would become 4'b1111, pulse frame_done and clear the mask on the same edge. Re-capturing a digit already in the mask only updates its value.

## Timing
- Inputs constant and selectable, first sampled at edge e1: capture registers update at edge e(SETTLE_CYCLES+1). Default latency is 5 edges from the first sample.
- SETTLE_CYCLES=1: capture at edge e2.
- frame_done and err are asserted for exactly the one cycle following the capture edge.
- Reset values: digits=0, dp=0, valid=0, frame_done=0, err=0, err_digit=0, mask=0, state IDLE, s_an=4'hF, s_seg=8'hFF.
- Reset asserted mid-settle or mid-frame discards all progress with no pulse. Capture restarts from a fresh run after release.
- A change on the capture edge itself does not cancel that capture; the new value starts a fresh run.

## Configuration
- SSD_DP_CAPTURE_EN defined: on each valid capture, dp[i] ← ~s_seg[7].
- SSD_DP_CAPTURE_EN undefined: dp is tied to 4'b0000 and s_seg[7] is ignored. Decode always ignores bit 7.

## Structure
- Shared package ssd_pkg holds:
  - segment glyph constants SEG_0…SEG_9 (lit patterns, HGFEDCBA);
  - a state enum {IDLE, SETTLE, HOLD};
  - NUM_DIGITS=4.
- Sub-module ssd_glyph_decoder: combinational seg[6:0] → {hit, nibble[3:0]}, active-low input.

## Test plan
- Reset: assert rst mid-run after two digits captured → all outputs 0 within the same cycle. After release, a digit held 4 cycles is captured normally.
- Single digit: an=4'b1110, seg=8'hB0 (3) held from e1 → digits[3:0]=3 and valid=4'b0001 at e5; no frame_done.
- Full frame: scan 1,2,3,4 on digits 0..3, 6 cycles each → digits=16'h4321, valid=4'hF. One frame_done pulse after the digit-3 capture; a second frame yields a second pulse.
- Glitch: an=4'b1101 with seg=8'hA4 held 2 cycles, then 8'hF9 held 4 cycles → only 1 is captured in digit 1; 2 never appears.
- Invalid and blank: seg=8'hFF on an=4'b1011 held 4 cycles → err pulse with err_digit=2; digits, valid and mask unchanged. an=4'b1100 held 10 cycles → no capture and no err.
- DP: with SSD_DP_CAPTURE_EN, seg=8'h40 (0 plus dp) on digit 0 → dp[0]=1, digits[3:0]=0. Without the macro → dp=0.
